line_clear_ctrl: RTL and testbench

// Sequences the board row memory after a piece locks: scans rows bottom-up,

---
 rtl/line_clear_ctrl_if.sv | 43 ++++
 rtl/line_clear_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_line_clear_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/line_clear_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : line_clear_ctrl_if
//  Description : Row RAM bus between the line-clear sequencer and the board
//                row memory. It carries one read port and one write port.
//                - master (sequencer): drives rd_en/rd_addr and
//                  wr_en/wr_addr/wr_data, and receives rd_data.
//                - slave (row RAM): receives the strobes, addresses and write
//                  data, and drives rd_data one cycle after rd_en. rd_data
//                  holds its value until the next read.
//  Revision    : 1.0 - initial release
// ============================================================================
interface line_clear_ctrl_if #(
  parameter int ROW_AW = 5,
  parameter int COLS   = 10,
  parameter int CELL_W = 3
);
  logic                     rd_en;
  logic [ROW_AW-1:0]        rd_addr;
  logic [COLS*CELL_W-1:0]   rd_data;
  logic                     wr_en;
  logic [ROW_AW-1:0]        wr_addr;
  logic [COLS*CELL_W-1:0]   wr_data;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface
`default_nettype wire

// File: rtl/line_clear_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : line_clear_ctrl
//  Description : Line-clear sequencer. After a piece locks, it scans the board
//                rows bottom-up. Full rows are dropped, the remaining rows are
//                compacted downward, and the freed rows at the top are
//                zero-filled. The module also keeps the running score and the
//                total cleared-line count.
//  Ports       : Clk, Reset_n       clock, asynchronous active-low reset
//                start              1-cycle pulse: a piece was written
//                ram (master)       row RAM read/write bus
//                busy               sweep in progress (freezes block logic)
//                done               1-cycle pulse at the end of a sweep
//                lines_cleared      full rows removed by the last sweep
//                score              running score, saturating
//                total_lines        running line count, saturating at 1023
//  Revision    : 1.0 - initial release
// ============================================================================
module line_clear_ctrl #(
  parameter int ROWS    = 20,
  parameter int COLS    = 10,
  parameter int CELL_W  = 3,
  parameter int ROW_AW  = 5,
  parameter int SCORE_W = 20   // must be >= 11 so that the 1200-point award fits
) (
  input  wire logic               Clk,
  input  wire logic               Reset_n,
  input  wire logic               start,
  line_clear_ctrl_if.master       ram,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              lines_cleared,
  output logic [SCORE_W-1:0]      score,
  output logic [9:0]              total_lines
);

  localparam logic [ROW_AW-1:0] C_LAST_ROW = ROW_AW'(ROWS - 1);
  localparam logic [ROW_AW-1:0] C_ROW_ONE  = ROW_AW'(1);
  localparam logic [10:0]       C_PTS_1    = 11'd40;
  localparam logic [10:0]       C_PTS_2    = 11'd100;
  localparam logic [10:0]       C_PTS_3    = 11'd300;
  localparam logic [10:0]       C_PTS_4    = 11'd1200;
  localparam logic [9:0]        C_LINES_MAX = 10'd1023;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_EVAL = 3'd3,
    S_FILL = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t              r_state;
  logic [ROW_AW-1:0]   r_src;
  logic [ROW_AW-1:0]   r_dst;
  logic [2:0]          r_cnt;
  logic                r_rd_en;
  logic [ROW_AW-1:0]   r_rd_addr;
  logic                r_busy;
  logic                r_done;
  logic [2:0]          r_lines;
  logic [SCORE_W-1:0]  r_score;
  logic [9:0]          r_total;

  logic                w_row_full;
  logic [2:0]          w_cnt_inc;
  logic [2:0]          w_eval_cnt;
  logic                w_eval_wr;
  logic                w_fill_wr;
  logic                w_wr_en;
  logic                w_to_done;
  logic [2:0]          w_fin_cnt;
  logic [10:0]         w_points;
  logic [SCORE_W:0]    w_score_sum;
  logic [SCORE_W-1:0]  w_score_nxt;
  logic [10:0]         w_total_sum;
  logic [9:0]          w_total_nxt;

  // A row is full only when every cell holds a non-zero color.
  always_comb begin
    w_row_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (ram.rd_data[c*CELL_W +: CELL_W] == '0) begin
        w_row_full = 1'b0;
      end
    end
  end

  assign w_cnt_inc  = (r_cnt == 3'd7) ? r_cnt : r_cnt + 3'd1;
  assign w_eval_cnt = w_row_full ? w_cnt_inc : r_cnt;

  // The row data only arrives in EVAL, so the compaction write is decoded
  // from the live read data. A kept row that is already in place
  // (src == dst) is skipped.
  assign w_eval_wr = (r_state == S_EVAL) && !w_row_full && (r_src != r_dst);
  assign w_fill_wr = (r_state == S_FILL);
  assign w_wr_en   = w_eval_wr | w_fill_wr;

  assign w_to_done = ((r_state == S_EVAL) && (r_src == '0) && (w_eval_cnt == 3'd0)) ||
                     ((r_state == S_FILL) && (r_dst == '0));

  // On the EVAL exit path the count is the freshly updated one.
  assign w_fin_cnt = (r_state == S_EVAL) ? w_eval_cnt : r_cnt;

  always_comb begin
    case (w_fin_cnt)
      3'd0:    w_points = 11'd0;
      3'd1:    w_points = C_PTS_1;
      3'd2:    w_points = C_PTS_2;
      3'd3:    w_points = C_PTS_3;
      default: w_points = C_PTS_4;
    endcase
  end

  assign w_score_sum = {1'b0, r_score} + (SCORE_W+1)'(w_points);
  assign w_score_nxt = w_score_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_score_sum[SCORE_W-1:0];
  assign w_total_sum = {1'b0, r_total} + {8'd0, w_fin_cnt};
  assign w_total_nxt = w_total_sum[10] ? C_LINES_MAX : w_total_sum[9:0];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_cnt     <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_lines   <= '0;
      r_score   <= '0;
      r_total   <= '0;
    end else begin
      r_done    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;

      case (r_state)
        S_IDLE: begin
          // Any start pulse outside IDLE falls through and is dropped.
          if (start) begin
            r_src     <= C_LAST_ROW;
            r_dst     <= C_LAST_ROW;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_rd_en   <= 1'b1;
            r_rd_addr <= C_LAST_ROW;
            r_state   <= S_RD;
          end
        end

        S_RD: begin
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          r_state <= S_EVAL;
        end

        S_EVAL: begin
          r_cnt <= w_eval_cnt;
          // Full rows do not consume a destination slot.
          if (!w_row_full) begin
            r_dst <= r_dst - C_ROW_ONE;
          end
          if (r_src == '0) begin
            if (w_eval_cnt != 3'd0) begin
              r_state <= S_FILL;
            end
          end else begin
            r_src     <= r_src - C_ROW_ONE;
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_src - C_ROW_ONE;
            r_state   <= S_RD;
          end
        end

        S_FILL: begin
          if (r_dst != '0) begin
            r_dst <= r_dst - C_ROW_ONE;
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_src   <= '0;
          r_dst   <= '0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Both exit paths (EVAL with nothing cleared, and the last FILL row)
      // share the same bookkeeping.
      if (w_to_done) begin
        r_state <= S_DONE;
        r_done  <= 1'b1;
        r_lines <= w_fin_cnt;
        r_score <= w_score_nxt;
        r_total <= w_total_nxt;
      end
    end
  end

  assign ram.rd_en   = r_rd_en;
  assign ram.rd_addr = r_rd_addr;
  assign ram.wr_en   = w_wr_en;
  assign ram.wr_addr = w_wr_en ? r_dst : '0;
  assign ram.wr_data = w_eval_wr ? ram.rd_data : '0;

  assign busy          = r_busy;
  assign done          = r_done;
  assign lines_cleared = r_lines;
  assign score         = r_score;
  assign total_lines   = r_total;

endmodule
`default_nettype wire

// File: tb/tb_line_clear_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_clear_ctrl
//  Description : Self-checking bench for line_clear_ctrl. A table of board
//                layouts is applied one sweep at a time. Expected RAM writes
//                are queued when each sweep is launched, and then matched
//                against the writes the DUT actually issued. A hand-written
//                mid-FILL reset sequence follows the table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_clear_ctrl;

  localparam int ROWS    = 20;
  localparam int COLS    = 10;
  localparam int CELL_W  = 3;
  localparam int ROW_AW  = 5;
  localparam int SCORE_W = 11;
  localparam int ROW_W   = COLS*CELL_W;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic               rst_n;
  logic               start;
  logic               busy;
  logic               done;
  logic [2:0]         lines;
  logic [SCORE_W-1:0] score;
  logic [9:0]         total;

  line_clear_ctrl_if #(.ROW_AW(ROW_AW), .COLS(COLS), .CELL_W(CELL_W)) bus ();

  line_clear_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W), .ROW_AW(ROW_AW), .SCORE_W(SCORE_W)
  ) dut (
    .Clk(clk),
    .Reset_n(rst_n),
    .start(start),
    .ram(bus),
    .busy(busy),
    .done(done),
    .lines_cleared(lines),
    .score(score),
    .total_lines(total)
  );

  // Row RAM model: synchronous read, and the read data is held until the
  // next read. A bulk preload is done while the DUT is idle.
  logic [ROW_W-1:0] mem     [0:31];
  logic [ROW_W-1:0] preload [0:31];
  logic             do_load;
  logic [ROW_W-1:0] rd_q;

  always @(posedge clk) begin
    if (do_load) begin
      for (int i = 0; i < 32; i++) mem[i] <= preload[i];
    end else begin
      if (bus.rd_en) rd_q <= mem[bus.rd_addr];
      if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    end
  end
  assign bus.rd_data = rd_q;

  // Cumulative activity monitor (sole writer of these variables).
  int               busy_cyc    = 0;
  int               done_cyc    = 0;
  int               overlap_cyc = 0;
  int               log_n       = 0;
  logic [ROW_AW-1:0] log_a [0:511];
  logic [ROW_W-1:0]  log_d [0:511];

  always @(negedge clk) begin
    if (busy) busy_cyc++;
    if (done) done_cyc++;
    if (bus.rd_en && bus.wr_en) overlap_cyc++;
    if (bus.wr_en) begin
      log_a[log_n % 512] = bus.wr_addr;
      log_d[log_n % 512] = bus.wr_data;
      log_n++;
    end
  end

  typedef struct {
    logic [31:0] full_m;
    logic [31:0] part_m;
    int          extra_starts;
    int          exp_lines;
    int          exp_score;
    int          exp_total;
    int          exp_busy;
  } vec_t;

  typedef logic [ROW_AW+ROW_W-1:0] wr_t;

  vec_t tbl [6];
  wr_t  exp_q [$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] row_val(input int r, input bit full);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int k = 0; k < COLS; k++) v[k*CELL_W +: CELL_W] = 3'(((r + k) % 7) + 1);
    if (!full) v[CELL_W-1:0] = '0;
    return v;
  endfunction

  task automatic run_case(input vec_t v, input string tag);
    logic [ROW_W-1:0] b  [0:ROWS-1];
    logic [ROW_W-1:0] nb [0:ROWS-1];
    int dst, b0, d0, o0, l0, n_obs, guard, badrow;
    wr_t e, got;

    for (int r = 0; r < 32; r++) preload[r] = '0;
    for (int r = 0; r < ROWS; r++) begin
      b[r] = v.full_m[r] ? row_val(r, 1'b1) : (v.part_m[r] ? row_val(r, 1'b0) : '0);
      preload[r] = b[r];
    end
    @(negedge clk) do_load = 1'b1;
    @(negedge clk) do_load = 1'b0;

    // Reference compaction: kept rows slide down in order, and the freed
    // rows at the top are zeroed.
    exp_q.delete();
    dst = ROWS - 1;
    for (int s = ROWS - 1; s >= 0; s--) begin
      if (!v.full_m[s]) begin
        if (s != dst) exp_q.push_back({ROW_AW'(dst), b[s]});
        nb[dst] = b[s];
        dst--;
      end
    end
    for (int r = dst; r >= 0; r--) begin
      exp_q.push_back({ROW_AW'(r), {ROW_W{1'b0}}});
      nb[r] = '0;
    end

    b0 = busy_cyc; d0 = done_cyc; o0 = overlap_cyc; l0 = log_n;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < v.extra_starts; k++) begin
      repeat (9) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    guard = 0;
    while (!done && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " done_seen"}, done, 1);
    repeat (4) @(negedge clk);

    check({tag, " busy_len"},   busy_cyc - b0, v.exp_busy);
    check({tag, " done_count"}, done_cyc - d0, 1);
    check({tag, " busy_after"}, busy, 0);
    check({tag, " overlap"},    overlap_cyc - o0, 0);
    check({tag, " lines"},      lines, v.exp_lines);
    check({tag, " score"},      score, v.exp_score);
    check({tag, " total"},      total, v.exp_total);

    n_obs = log_n - l0;
    check({tag, " wr_count"}, n_obs, exp_q.size());
    for (int j = 0; j < n_obs && exp_q.size() > 0; j++) begin
      e   = exp_q.pop_front();
      got = {log_a[(l0 + j) % 512], log_d[(l0 + j) % 512]};
      check({tag, " wr_addr_data"}, got, e);
    end
    exp_q.delete();

    badrow = -1;
    for (int r = 0; r < ROWS; r++) if (mem[r] !== nb[r] && badrow < 0) badrow = r;
    check({tag, " board_bad_row"}, badrow, -1);
  endtask

  initial begin : main
    vec_t v;
    int guard;

    //              full_m        part_m        xs lines score  total busy
    tbl[0] = '{32'h0000_0000, 32'h0000_0000, 0, 0,    0,     0,   61};
    tbl[1] = '{32'h0008_0000, 32'h0006_0000, 0, 1,   40,     1,   62};
    tbl[2] = '{32'h000F_0000, 32'h0000_8000, 0, 4, 1240,     5,   65};
    tbl[3] = '{32'h000A_0000, 32'h0005_0000, 3, 2, 1340,     7,   63};
    tbl[4] = '{32'h000F_0000, 32'h0000_0001, 0, 4, 2047,    11,   65};
    tbl[5] = '{32'h0000_0401, 32'h0000_0020, 0, 2, 2047,    13,   63};

    rst_n = 1'b0; start = 1'b0; do_load = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy",  busy, 0);
    check("rst done",  done, 0);
    check("rst score", score, 0);
    check("rst total", total, 0);
    check("rst rd_en", bus.rd_en, 0);
    check("rst wr_en", bus.wr_en, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_case(tbl[i], $sformatf("case%0d", i));

    // Reset in the middle of FILL: rows 17-19 full, so the zero-fill
    // writes rows 2, 1, 0. The first write to row 2 happens in FILL.
    for (int r = 0; r < 32; r++) preload[r] = (r >= 17 && r < ROWS) ? row_val(r, 1'b1) : '0;
    @(negedge clk) do_load = 1'b1;
    @(negedge clk) do_load = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    guard = 0;
    while (!(bus.wr_en && bus.wr_addr == 5'd2) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("midfill reached", bus.wr_en && bus.wr_addr == 5'd2, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst busy",  busy, 0);
    check("midrst wr_en", bus.wr_en, 0);
    check("midrst rd_en", bus.rd_en, 0);
    check("midrst score", score, 0);
    check("midrst total", total, 0);
    check("midrst lines", lines, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("postrst idle busy", busy, 0);

    v = '{32'h0008_0000, 32'h0000_0000, 0, 1, 40, 1, 62};
    run_case(v, "postrst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
